// File: rtl/send_packet_tx_pkg.sv
// rtl/send_packet_tx_pkg.sv - PID constants, Tx control codes and FSM encoding for the send-packet path
package send_packet_tx_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_PING  = 4'h4;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [7:0] SOP_CNTL_CODE  = 8'h01;
    localparam logic [7:0] DATA_CNTL_CODE = 8'h00;
    localparam logic [7:0] EOP_CNTL_CODE  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_PID,
        ST_BYTE1,
        ST_BYTE2,
        ST_DONE
    } tx_state_t;

    function automatic logic is_token(input logic [3:0] pid);
        return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP) ||
               (pid == PID_PING) || (pid == PID_SOF);
    endfunction

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_crc5.sv
// rtl/usb_crc5.sv - combinational USB token CRC5 over an 11-bit field
module usb_crc5 (
    input  logic [10:0] data,
    output logic [4:0]  crc
);

    logic [4:0] lfsr;
    logic       fb;

    always_comb begin
        lfsr = 5'h1f;
        fb   = 1'b0;
        for (int i = 0; i < 11; i++) begin
            fb   = data[i] ^ lfsr[4];
            lfsr = {lfsr[3:0], 1'b0} ^ ({5{fb}} & 5'b00101);
        end
        // Bit-reversed so crc[0] lands on the byte bit transmitted first.
        crc = ~{lfsr[0], lfsr[1], lfsr[2], lfsr[3], lfsr[4]};
    end

endmodule

// File: rtl/send_packet_tx.sv
// rtl/send_packet_tx.sv - formats send-packet commands into USB bytes on the shared Tx port
module send_packet_tx
    import send_packet_tx_pkg::*;
#(
    parameter logic [7:0] SOP_CNTL  = SOP_CNTL_CODE,
    parameter logic [7:0] DATA_CNTL = DATA_CNTL_CODE,
    parameter logic [7:0] EOP_CNTL  = EOP_CNTL_CODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sendPacketPID,
    input  logic        sendPacketWEnable,
    input  logic [6:0]  TxAddr,
    input  logic [3:0]  TxEndP,
    input  logic [10:0] frameNum,
    output logic        sendPacketRdy,
    output logic        TxPortReq,
    input  logic        TxPortGnt,
    input  logic        TxPortRdy,
    output logic        TxPortWEn,
    output logic [7:0]  TxPortData,
    output logic [7:0]  TxPortCntl
);

    tx_state_t   state;
    logic [3:0]  pid_q;
    logic [6:0]  addr_q;
    logic [3:0]  endp_q;
    logic [10:0] frame_q;
    logic        sof_q;
    logic [10:0] crc_field;
    logic [4:0]  crc5;
    logic        can_write;

    assign crc_field = sof_q ? frame_q : {endp_q, addr_q};

    usb_crc5 u_crc5 (
        .data (crc_field),
        .crc  (crc5)
    );

    // The WEn guard keeps a gap cycle between bytes even if the port holds Rdy high.
    assign can_write = TxPortGnt && TxPortRdy && !TxPortWEn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            sendPacketRdy <= 1'b1;
            TxPortReq     <= 1'b0;
            TxPortWEn     <= 1'b0;
            TxPortData    <= 8'h00;
            TxPortCntl    <= 8'h00;
            pid_q         <= 4'h0;
            addr_q        <= 7'h00;
            endp_q        <= 4'h0;
            frame_q       <= 11'h000;
            sof_q         <= 1'b0;
        end else begin
            TxPortWEn <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sendPacketWEnable) begin
                        pid_q         <= sendPacketPID;
                        addr_q        <= TxAddr;
                        endp_q        <= TxEndP;
                        frame_q       <= frameNum;
                        sof_q         <= (sendPacketPID == PID_SOF);
                        sendPacketRdy <= 1'b0;
                        TxPortReq     <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (TxPortGnt) begin
                        state <= ST_PID;
                    end
                end
                ST_PID: begin
                    if (can_write) begin
                        TxPortWEn  <= 1'b1;
                        TxPortData <= {~pid_q, pid_q};
                        if (is_token(pid_q) || is_data_pid(pid_q)) begin
                            TxPortCntl <= SOP_CNTL;
                        end else begin
                            TxPortCntl <= SOP_CNTL | EOP_CNTL;
                        end
                        state <= is_token(pid_q) ? ST_BYTE1 : ST_DONE;
                    end
                end
                ST_BYTE1: begin
                    if (can_write) begin
                        TxPortWEn  <= 1'b1;
                        TxPortData <= sof_q ? frame_q[7:0] : {endp_q[0], addr_q};
                        TxPortCntl <= DATA_CNTL;
                        state      <= ST_BYTE2;
                    end
                end
                ST_BYTE2: begin
                    if (can_write) begin
                        TxPortWEn  <= 1'b1;
                        TxPortData <= sof_q ? {crc5, frame_q[10:8]} : {crc5, endp_q[3:1]};
                        TxPortCntl <= EOP_CNTL;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    TxPortReq     <= 1'b0;
                    sendPacketRdy <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
